i2c_arbiter: RTL and testbench
==============================

I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 4096, is the maximum number of clk cycles allowed per transaction phase before recovery is triggered.
REQ-002 clk  input  1  system clock (16 MHz); all logic is on its rising edge.
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 req  input  4  per-requester transaction request, level, held until done.
REQ-005 req_addr  input  32  four packed 8-bit fields, one per requester: 7-bit slave address in [6:0], read/write flag in bit 7 (1 = read).
REQ-006 req_wdata  input  32  four packed 8-bit write bytes, one per requester.
REQ-007 req_fast  input  4  per-requester speed select: 1 = 400 kbps, 0 = 100 kbps.
REQ-008 gnt  output  4  one-hot grant, held for the whole transaction.
REQ-009 done  output  4  one-hot, one-cycle completion pulse to the granted requester.
REQ-010 err  output  1  one-cycle pulse coincident with done when the transaction timed out.
REQ-011 rdata  output  8  read byte, valid from the done pulse until the next done pulse.
REQ-012 busy  output  1  high whenever the state is not IDLE.
REQ-013 mst_cmd  output  4  command to the I2C master: bit0 = start, bit2 = reset, bit3 = speed; bit1 is always 0.
REQ-014 mst_addr, mst_wdata  output  8 each  address and data presented to the I2C master.
REQ-015 mst_rdata  input  8  read byte from the I2C master.
REQ-016 mst_ready  input  1  master status: low while a transaction is in progress, high when idle.

Function
REQ-017 All outputs shall be registered.
REQ-018 The FSM shall have exactly these states: IDLE, ISSUE, WAIT_DONE, RECOVER.
REQ-019 IDLE: when req is nonzero at edge T, the arbiter shall pick a winner and enter ISSUE, with gnt, mst_addr, mst_wdata and mst_cmd valid from T+1.
- Winner selection is round-robin.
- The search starts at the index after the last granted requester.
- After reset, requester 0 has highest priority.
REQ-020 The round-robin pointer shall update only when a grant is issued.
REQ-021 The winner's addr, wdata and fast fields shall be latched at grant and held constant until return to IDLE.
REQ-022 ISSUE: mst_cmd shall equal {fast,0,0,1}.
- When mst_ready is sampled low, the FSM shall clear mst_cmd[0] and enter WAIT_DONE.
REQ-023 WAIT_DONE: when mst_ready is sampled high, the following shall occur on the next edge, and the FSM shall return to IDLE:
- capture mst_rdata into rdata;
- pulse done[gnt index] for one cycle;
- clear gnt.
REQ-024 A new grant shall not be issued in the cycle done pulses; minimum spacing between consecutive mst_cmd[0] assertions is 2 cycles.
REQ-025 A 16-bit timeout counter shall clear on entry to ISSUE and on entry to WAIT_DONE, and shall increment every cycle in those states.
REQ-026 When the timeout counter reaches TIMEOUT_CYCLES-1, the FSM shall enter RECOVER.
REQ-027 RECOVER shall last exactly 1 cycle, with all of the following in that cycle:
- mst_cmd = 4'b0100;
- done[gnt index] = 1;
- err = 1;
- rdata unchanged.
- The next state is IDLE with gnt cleared.
REQ-028 Deassertion of the granted req mid-transaction shall be ignored; the transaction completes and done still pulses.
REQ-029 Changes on non-granted req bits during a transaction shall not affect gnt.
REQ-030 When multiple requests are pending, they shall be served one transaction per grant in round-robin order; no requester is skipped while its req is held.
REQ-031 When mst_ready is already low on entry to ISSUE (master busy from an external cause), the FSM shall treat it as accepted and proceed to WAIT_DONE.

Reset
REQ-032 rst shall override all state, including mid-transaction.
REQ-033 Reset values shall be:
- FSM = IDLE;
- gnt, done, err, busy, rdata = 0;
- mst_cmd = 4'b0000;
- mst_addr, mst_wdata = 0;
- round-robin pointer such that requester 0 wins next;
- timeout counter = 0.
REQ-034 No done or err pulse shall be generated by a reset.

Verification
REQ-035 Single read: req=0001, req_addr[7:0]=8'hA1, req_fast[0]=1; master model drops mst_ready 3 cycles after start, raises it 50 cycles later with mst_rdata=8'h5C -> gnt=0001, mst_cmd=4'b1001 until accept, done=0001 one cycle, rdata=8'h5C, err=0.
REQ-036 Contention: req=1111 held, fixed 10-cycle master -> grants in order 0001, 0010, 0100, 1000, 0001; never two bits set in gnt.
REQ-037 Pointer fairness: requester 2 served, then req=0101 -> next grant is 0001 only if requester 3 is idle, i.e. the search order is 3, 0, 1, 2.
REQ-038 Timeout: TIMEOUT_CYCLES=64, master never drops mst_ready -> RECOVER after 64 cycles in ISSUE, mst_cmd=4'b0100 for one cycle, done and err pulse together, busy low on the next cycle.
REQ-039 Reset mid-transaction: rst asserted during WAIT_DONE -> next cycle all outputs at reset values, no done pulse; a subsequent req=0010 is granted normally.
REQ-040 Withdrawal: the granted req dropped during WAIT_DONE -> transaction completes, done pulses, and no regrant occurs for that requester.

Source files
------------

// File: rtl/i2c_arbiter_if.sv
// Bundle of requester-side and I2C-master-side signals around the arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface i2c_arbiter_if;
   logic [3:0]  req;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_fast;
   logic [3:0]  gnt;
   logic [3:0]  done;
   logic        err;
   logic [7:0]  rdata;
   logic        busy;
   logic [3:0]  mst_cmd;
   logic [7:0]  mst_addr;
   logic [7:0]  mst_wdata;
   logic [7:0]  mst_rdata;
   logic        mst_ready;

   modport slave (
      input  req, req_addr, req_wdata, req_fast, mst_rdata, mst_ready,
      output gnt, done, err, rdata, busy, mst_cmd, mst_addr, mst_wdata
   );

   modport master (
      output req, req_addr, req_wdata, req_fast, mst_rdata, mst_ready,
      input  gnt, done, err, rdata, busy, mst_cmd, mst_addr, mst_wdata
   );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C master among four requesters, with a
// per-phase timeout that forces a one-cycle master reset and error completion.
module i2c_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input logic         clk,
   input logic         rst,
   i2c_arbiter_if.slave bus_io
);

   localparam logic [1:0] StIdle     = 2'd0;
   localparam logic [1:0] StIssue    = 2'd1;
   localparam logic [1:0] StWaitDone = 2'd2;
   localparam logic [1:0] StRecover  = 2'd3;

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT_CYCLES - 1);

   logic [1:0]  state_q, state_d;
   logic [1:0]  ptr_q, ptr_d;
   logic [15:0] cnt_q, cnt_d;
   logic [3:0]  gnt_q, gnt_d;
   logic [3:0]  done_q, done_d;
   logic        err_q, err_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        busy_q, busy_d;
   logic [3:0]  mst_cmd_q, mst_cmd_d;
   logic [7:0]  mst_addr_q, mst_addr_d;
   logic [7:0]  mst_wdata_q, mst_wdata_d;

   logic        win_valid;
   logic [1:0]  win_idx;
   logic [1:0]  cand;

   // Search starts one past the last granted index and wraps around.
   always_comb begin
      win_valid = 1'b0;
      win_idx   = ptr_q;
      cand      = '0;
      for (int k = 1; k <= 4; k++) begin
         cand = ptr_q + 2'(k);
         if (!win_valid && bus_io.req[cand]) begin
            win_valid = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      ptr_d       = ptr_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      done_d      = '0;
      err_d       = 1'b0;
      rdata_d     = rdata_q;
      busy_d      = busy_q;
      mst_cmd_d   = mst_cmd_q;
      mst_addr_d  = mst_addr_q;
      mst_wdata_d = mst_wdata_q;

      unique case (state_q)
         StIdle: begin
            if (win_valid) begin
               state_d     = StIssue;
               ptr_d       = win_idx;
               cnt_d       = '0;
               gnt_d       = 4'b0001 << win_idx;
               busy_d      = 1'b1;
               mst_addr_d  = bus_io.req_addr[{win_idx, 3'b000} +: 8];
               mst_wdata_d = bus_io.req_wdata[{win_idx, 3'b000} +: 8];
               mst_cmd_d   = {bus_io.req_fast[win_idx], 3'b001};
            end
         end
         StIssue: begin
            // A master already busy on entry counts as acceptance.
            if (!bus_io.mst_ready) begin
               state_d      = StWaitDone;
               cnt_d        = '0;
               mst_cmd_d[0] = 1'b0;
            end else if (cnt_q == TimeoutLast) begin
               state_d   = StRecover;
               mst_cmd_d = 4'b0100;
               done_d    = gnt_q;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StWaitDone: begin
            if (bus_io.mst_ready) begin
               state_d   = StIdle;
               rdata_d   = bus_io.mst_rdata;
               done_d    = gnt_q;
               gnt_d     = '0;
               busy_d    = 1'b0;
               mst_cmd_d = '0;
            end else if (cnt_q == TimeoutLast) begin
               state_d   = StRecover;
               mst_cmd_d = 4'b0100;
               done_d    = gnt_q;
               err_d     = 1'b1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         StRecover: begin
            state_d   = StIdle;
            gnt_d     = '0;
            busy_d    = 1'b0;
            mst_cmd_d = '0;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Reset value 3 makes requester 0 the first candidate.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         ptr_q       <= 2'd3;
         cnt_q       <= '0;
         gnt_q       <= '0;
         done_q      <= '0;
         err_q       <= 1'b0;
         rdata_q     <= '0;
         busy_q      <= 1'b0;
         mst_cmd_q   <= '0;
         mst_addr_q  <= '0;
         mst_wdata_q <= '0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata_q     <= rdata_d;
         busy_q      <= busy_d;
         mst_cmd_q   <= mst_cmd_d;
         mst_addr_q  <= mst_addr_d;
         mst_wdata_q <= mst_wdata_d;
      end
   end

   assign bus_io.gnt       = gnt_q;
   assign bus_io.done      = done_q;
   assign bus_io.err       = err_q;
   assign bus_io.rdata     = rdata_q;
   assign bus_io.busy      = busy_q;
   assign bus_io.mst_cmd   = mst_cmd_q;
   assign bus_io.mst_addr  = mst_addr_q;
   assign bus_io.mst_wdata = mst_wdata_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: behavioural I2C master plus a round-robin reference
// model; each scenario task checks its own observations against the model.
module tb_i2c_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   i2c_arbiter_if bus();

   i2c_arbiter #(.TIMEOUT_CYCLES(64)) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;

   // Master model knobs.
   bit         m_never = 1'b0;
   bit         m_fix   = 1'b0;
   logic [7:0] m_fixval = 8'h00;
   int         m_acc = 3;
   int         m_dur = 10;
   logic [7:0] m_rdata = 8'h00;

   // Reference model state: last granted index and the rdata the arbiter should hold.
   int         rr_last = 3;
   logic [7:0] mdl_rdata = 8'h00;

   initial begin
      bus.mst_ready = 1'b1;
      bus.mst_rdata = 8'h00;
      forever begin
         @(negedge clk);
         if (bus.mst_cmd[0] === 1'b1 && !m_never) begin
            repeat (m_acc) @(negedge clk);
            bus.mst_ready = 1'b0;
            repeat (m_dur) @(negedge clk);
            m_rdata = m_fix ? m_fixval : 8'($urandom);
            bus.mst_rdata = m_rdata;
            bus.mst_ready = 1'b1;
         end
      end
   end

   function automatic int rr_pick(input int last, input logic [3:0] r);
      for (int k = 1; k <= 4; k++) begin
         if (r[(last + k) % 4]) return (last + k) % 4;
      end
      return -1;
   endfunction

   task automatic wait_grant(output logic [3:0] g, output bit ok);
      ok = 1'b0;
      g  = '0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.gnt !== 4'b0000) begin
            g  = bus.gnt;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_done(output logic [3:0] d, output logic e, output logic [7:0] r,
                            output bit ok);
      ok = 1'b0;
      d  = '0;
      e  = 1'b0;
      r  = '0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (bus.done !== 4'b0000) begin
            d  = bus.done;
            e  = bus.err;
            r  = bus.rdata;
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic wait_ready_low(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.mst_ready === 1'b0) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst     = 1'b1;
      bus.req = '0;
      repeat (2) @(negedge clk);
      rst       = 1'b0;
      rr_last   = 3;
      mdl_rdata = 8'h00;
   endtask

   task automatic test_reset();
      bus.req       = '0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_fast  = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0000) begin
         errors++; $display("FAIL reset_gnt: got %b want 0000", bus.gnt);
      end
      checks++;
      if (bus.done !== 4'b0000 || bus.err !== 1'b0) begin
         errors++; $display("FAIL reset_done_err: got %b/%b want 0000/0", bus.done, bus.err);
      end
      checks++;
      if (bus.busy !== 1'b0) begin
         errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
      end
      checks++;
      if (bus.rdata !== 8'h00) begin
         errors++; $display("FAIL reset_rdata: got %h want 00", bus.rdata);
      end
      checks++;
      if (bus.mst_cmd !== 4'b0000) begin
         errors++; $display("FAIL reset_cmd: got %b want 0000", bus.mst_cmd);
      end
      checks++;
      if (bus.mst_addr !== 8'h00 || bus.mst_wdata !== 8'h00) begin
         errors++;
         $display("FAIL reset_mst_bytes: got %h/%h want 00/00", bus.mst_addr, bus.mst_wdata);
      end
      rst = 1'b0;
      rr_last = 3;
      mdl_rdata = 8'h00;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
         errors++; $display("FAIL idle_after_reset: busy %b gnt %b want 0/0000", bus.busy, bus.gnt);
      end
   endtask

   task automatic test_single_read();
      logic [3:0] g, d;
      logic       e;
      logic [7:0] r;
      bit         ok;
      bus.req_addr  = {24'($urandom), 8'hA1};
      bus.req_wdata = $urandom;
      bus.req_fast  = 4'b0001;
      m_fix = 1'b1; m_fixval = 8'h5C; m_acc = 3; m_dur = 50;
      bus.req = 4'b0001;
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== 4'b0001) begin
         errors++; $display("FAIL single_gnt: got %b want 0001", g);
      end
      rr_last = 0;
      checks++;
      if (bus.mst_cmd !== 4'b1001 || bus.mst_addr !== 8'hA1) begin
         errors++;
         $display("FAIL single_cmd: got %b/%h want 1001/a1", bus.mst_cmd, bus.mst_addr);
      end
      repeat (4) @(negedge clk);
      checks++;
      if (bus.mst_cmd !== 4'b1000 || bus.gnt !== 4'b0001) begin
         errors++;
         $display("FAIL single_accept: cmd %b gnt %b want 1000/0001", bus.mst_cmd, bus.gnt);
      end
      wait_done(d, e, r, ok);
      bus.req = '0;
      checks++;
      if (!ok || d !== 4'b0001 || e !== 1'b0 || r !== 8'h5C) begin
         errors++;
         $display("FAIL single_done: done %b err %b rdata %h want 0001/0/5c", d, e, r);
      end
      mdl_rdata = 8'h5C;
      @(negedge clk);
      checks++;
      if (bus.done !== 4'b0000 || bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
         errors++;
         $display("FAIL single_after: done %b busy %b gnt %b want 0000/0/0000",
                  bus.done, bus.busy, bus.gnt);
      end
      m_fix = 1'b0;
   endtask

   task automatic test_contention();
      logic [3:0] g, d;
      logic       e;
      logic [7:0] r;
      bit         ok;
      int         exp_idx;
      do_reset();
      m_acc = 2; m_dur = 8;
      bus.req = 4'b1111;
      for (int n = 0; n < 5; n++) begin
         wait_grant(g, ok);
         exp_idx = rr_pick(rr_last, 4'b1111);
         checks++;
         if (!ok || g !== (4'b0001 << exp_idx) || !$onehot(g)) begin
            errors++;
            $display("FAIL contention_gnt%0d: got %b want %b", n, g, 4'b0001 << exp_idx);
         end
         rr_last = exp_idx;
         wait_done(d, e, r, ok);
         checks++;
         if (!ok || d !== g || e !== 1'b0) begin
            errors++; $display("FAIL contention_done%0d: got %b/%b want %b/0", n, d, e, g);
         end
         mdl_rdata = m_rdata;
      end
      bus.req = '0;
   endtask

   task automatic test_fairness();
      logic [3:0] g, d;
      logic       e;
      logic [7:0] r;
      bit         ok;
      logic [3:0] pats [3];
      int         exp_idx;
      pats[0] = 4'b0100;
      pats[1] = 4'b0101;
      pats[2] = 4'b0101;
      m_acc = 1; m_dur = 5;
      for (int n = 0; n < 3; n++) begin
         @(negedge clk);
         bus.req = pats[n];
         wait_grant(g, ok);
         exp_idx = rr_pick(rr_last, pats[n]);
         checks++;
         if (!ok || g !== (4'b0001 << exp_idx)) begin
            errors++; $display("FAIL fairness_gnt%0d: got %b want %b", n, g, 4'b0001 << exp_idx);
         end
         rr_last = exp_idx;
         wait_done(d, e, r, ok);
         if (n != 1) bus.req = '0;
         checks++;
         if (!ok || d !== g || r !== m_rdata) begin
            errors++; $display("FAIL fairness_done%0d: got %b/%h want %b/%h", n, d, r, g, m_rdata);
         end
         mdl_rdata = m_rdata;
      end
   endtask

   task automatic test_timeout();
      logic [3:0] g;
      bit         ok;
      int         idx;
      int         n;
      idx = int'($urandom_range(0, 3));
      m_never = 1'b1;
      bus.req_fast = 4'($urandom);
      @(negedge clk);
      bus.req = 4'b0001 << idx;
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== (4'b0001 << idx)) begin
         errors++; $display("FAIL timeout_gnt: got %b want %b", g, 4'b0001 << idx);
      end
      rr_last = idx;
      n = 0;
      while (bus.mst_cmd[0] === 1'b1 && n < 300) begin
         n++;
         @(negedge clk);
      end
      checks++;
      if (n != 64) begin
         errors++; $display("FAIL timeout_issue_len: got %0d cycles want 64", n);
      end
      checks++;
      if (bus.mst_cmd !== 4'b0100 || bus.done !== g || bus.err !== 1'b1) begin
         errors++;
         $display("FAIL timeout_recover: cmd %b done %b err %b want 0100/%b/1",
                  bus.mst_cmd, bus.done, bus.err, g);
      end
      checks++;
      if (bus.rdata !== mdl_rdata) begin
         errors++; $display("FAIL timeout_rdata: got %h want %h", bus.rdata, mdl_rdata);
      end
      bus.req = '0;
      @(negedge clk);
      checks++;
      if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.err !== 1'b0) begin
         errors++;
         $display("FAIL timeout_after: busy %b gnt %b done %b err %b want 0/0000/0000/0",
                  bus.busy, bus.gnt, bus.done, bus.err);
      end
      m_never = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] g, d;
      logic       e;
      logic [7:0] r;
      bit         ok;
      bit         saw_done;
      bit         back;
      m_acc = 2; m_dur = 40;
      @(negedge clk);
      bus.req = 4'b1000;
      wait_grant(g, ok);
      rr_last = 3;
      wait_ready_low(ok);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      bus.req = '0;
      @(negedge clk);
      checks++;
      if (bus.gnt !== 4'b0000 || bus.done !== 4'b0000 || bus.err !== 1'b0 ||
          bus.busy !== 1'b0 || bus.mst_cmd !== 4'b0000 || bus.rdata !== 8'h00) begin
         errors++;
         $display("FAIL midreset_outputs: gnt %b done %b err %b busy %b cmd %b rdata %h",
                  bus.gnt, bus.done, bus.err, bus.busy, bus.mst_cmd, bus.rdata);
      end
      rst = 1'b0;
      rr_last = 3;
      mdl_rdata = 8'h00;
      saw_done = 1'b0;
      back = 1'b0;
      for (int i = 0; i < 100 && !back; i++) begin
         @(negedge clk);
         if (bus.done !== 4'b0000 || bus.err !== 1'b0) saw_done = 1'b1;
         if (bus.mst_ready === 1'b1) back = 1'b1;
      end
      checks++;
      if (saw_done || !back) begin
         errors++; $display("FAIL midreset_no_done: saw_done %b ready_back %b want 0/1", saw_done, back);
      end
      m_dur = 6;
      bus.req = 4'b0010;
      wait_grant(g, ok);
      checks++;
      if (!ok || g !== (4'b0001 << rr_pick(rr_last, 4'b0010))) begin
         errors++; $display("FAIL midreset_regrant: got %b want 0010", g);
      end
      rr_last = 1;
      wait_done(d, e, r, ok);
      bus.req = '0;
      checks++;
      if (!ok || d !== 4'b0010 || e !== 1'b0 || r !== m_rdata) begin
         errors++; $display("FAIL midreset_done: got %b/%b/%h want 0010/0/%h", d, e, r, m_rdata);
      end
      mdl_rdata = m_rdata;
   endtask

   task automatic test_withdraw();
      logic [3:0] g, d;
      logic       e;
      logic [7:0] r;
      bit         ok;
      bit         regrant;
      m_acc = 1; m_dur = 10;
      @(negedge clk);
      bus.req = 4'b0100;
      wait_grant(g, ok);
      rr_last = 2;
      wait_ready_low(ok);
      @(negedge clk);
      bus.req = '0;
      wait_done(d, e, r, ok);
      checks++;
      if (!ok || d !== 4'b0100 || e !== 1'b0 || r !== m_rdata) begin
         errors++; $display("FAIL withdraw_done: got %b/%b/%h want 0100/0/%h", d, e, r, m_rdata);
      end
      mdl_rdata = m_rdata;
      regrant = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (bus.gnt !== 4'b0000) regrant = 1'b1;
      end
      checks++;
      if (regrant) begin
         errors++; $display("FAIL withdraw_regrant: got regrant 1 want 0");
      end
   endtask

   task automatic test_random();
      logic [3:0] g, d;
      logic       e;
      logic [7:0] r;
      bit         ok;
      logic [3:0] reqv;
      int         exp_idx;
      for (int n = 0; n < 20; n++) begin
         reqv          = 4'($urandom_range(1, 15));
         bus.req_addr  = $urandom;
         bus.req_wdata = $urandom;
         bus.req_fast  = 4'($urandom);
         m_acc = int'($urandom_range(1, 4));
         m_dur = int'($urandom_range(1, 20));
         @(negedge clk);
         bus.req = reqv;
         wait_grant(g, ok);
         exp_idx = rr_pick(rr_last, reqv);
         checks++;
         if (!ok || g !== (4'b0001 << exp_idx)) begin
            errors++; $display("FAIL random%0d_gnt: got %b want %b", n, g, 4'b0001 << exp_idx);
         end
         checks++;
         if (bus.mst_addr !== bus.req_addr[8*exp_idx +: 8] ||
             bus.mst_wdata !== bus.req_wdata[8*exp_idx +: 8] ||
             bus.mst_cmd !== {bus.req_fast[exp_idx], 3'b001}) begin
            errors++;
            $display("FAIL random%0d_fields: addr %h wdata %h cmd %b want %h/%h/%b", n,
                     bus.mst_addr, bus.mst_wdata, bus.mst_cmd, bus.req_addr[8*exp_idx +: 8],
                     bus.req_wdata[8*exp_idx +: 8], {bus.req_fast[exp_idx], 3'b001});
         end
         rr_last = exp_idx;
         wait_done(d, e, r, ok);
         bus.req = '0;
         checks++;
         if (!ok || d !== g || e !== 1'b0 || r !== m_rdata) begin
            errors++;
            $display("FAIL random%0d_done: got %b/%b/%h want %b/0/%h", n, d, e, r, g, m_rdata);
         end
         mdl_rdata = m_rdata;
      end
   endtask

   initial begin
      bus.req = '0;
      test_reset();
      test_single_read();
      test_contention();
      test_fairness();
      test_timeout();
      test_reset_mid();
      test_withdraw();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
